// File: rtl/periph_bus_pkg.sv
// Shared widths and helpers for the peripheral bus decoder slice.
package periph_bus_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int ADDR_W = 32;

  // Slave index width, leaving room for the internal error slave at N.
  function automatic int slv_idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/periph_bus_decoder_if.sv
// Core data port plus per-slave request/response bundle for the decoder.
interface periph_bus_decoder_if
  import periph_bus_pkg::*;
#(
  parameter int N_SLAVES = 3
) ();

  logic                       data_req;
  logic                       data_we;
  logic [BE_W-1:0]            data_be;
  logic [ADDR_W-1:0]          data_addr;
  logic [DATA_W-1:0]          data_wdata;
  logic                       data_gnt;
  logic                       data_rvalid;
  logic [DATA_W-1:0]          data_rdata;
  logic                       data_err;

  logic [N_SLAVES-1:0]        slv_req;
  logic                       slv_we;
  logic [BE_W-1:0]            slv_be;
  logic [ADDR_W-1:0]          slv_addr;
  logic [DATA_W-1:0]          slv_wdata;
  logic [N_SLAVES-1:0]        slv_gnt;
  logic [N_SLAVES-1:0]        slv_rvalid;
  logic [N_SLAVES*DATA_W-1:0] slv_rdata;
  logic [N_SLAVES-1:0]        slv_err;

  logic                       proto_err;

  // Core and peripherals together, as seen from outside the decoder.
  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err,
    input  slv_req, slv_we, slv_be, slv_addr, slv_wdata,
    output slv_gnt, slv_rvalid, slv_rdata, slv_err,
    input  proto_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err,
    output slv_req, slv_we, slv_be, slv_addr, slv_wdata,
    input  slv_gnt, slv_rvalid, slv_rdata, slv_err,
    output proto_err
  );

endinterface

// File: rtl/periph_txn_fifo.sv
// In-order tracking FIFO of slave indices for accepted transactions.
module periph_txn_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // full is judged on the registered count, so a same-cycle pop never frees a slot
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/periph_bus_decoder.sv
// Address-decoding interconnect: one core data port to N slaves, in-order responses,
// local error slave for unmapped addresses and a sticky protocol-error flag.
module periph_bus_decoder
  import periph_bus_pkg::*;
#(
  parameter int N_SLAVES  = 3,
  parameter int MAX_OUTST = 2,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h1000_1000, 32'h0000_0000, 32'h1000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_F000}
) (
  input logic                 clk,
  input logic                 rst,
  periph_bus_decoder_if.slave bus
);

  localparam int IDX_W = slv_idx_w(N_SLAVES);
  localparam logic [IDX_W-1:0] ERR_IDX = IDX_W'(N_SLAVES);

  logic                hit;
  logic [IDX_W-1:0]    sel;
  logic [N_SLAVES-1:0] slv_req_d;
  logic                gnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic [IDX_W-1:0]    head;
  logic                rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                rerr;
  logic                out_of_order;
  logic                proto_err_q;

  // Scan downward so the lowest matching index is the one left in sel.
  always_comb begin
    hit = 1'b0;
    sel = ERR_IDX;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((bus.data_addr & SLV_MASK[ADDR_W*i +: ADDR_W]) == SLV_BASE[ADDR_W*i +: ADDR_W]) begin
        hit = 1'b1;
        sel = IDX_W'(i);
      end
    end
  end

  always_comb begin
    slv_req_d = '0;
    gnt       = 1'b0;
    if (bus.data_req && !fifo_full) begin
      if (!hit) begin
        gnt = 1'b1;
      end else begin
        for (int i = 0; i < N_SLAVES; i++) begin
          if (sel == IDX_W'(i)) begin
            slv_req_d[i] = 1'b1;
            gnt          = bus.slv_gnt[i];
          end
        end
      end
    end
  end

  always_comb begin
    rvalid       = 1'b0;
    rdata        = '0;
    rerr         = 1'b0;
    out_of_order = 1'b0;
    if (!fifo_empty && head == ERR_IDX) begin
      rvalid = 1'b1;
      rerr   = 1'b1;
    end
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!fifo_empty && head == IDX_W'(i)) begin
        if (bus.slv_rvalid[i]) begin
          rvalid = 1'b1;
          rdata  = bus.slv_rdata[DATA_W*i +: DATA_W];
          rerr   = bus.slv_err[i];
        end
      end else if (bus.slv_rvalid[i]) begin
        out_of_order = 1'b1;
      end
    end
  end

  periph_txn_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_txn_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt),
    .pop   (rvalid),
    .din   (sel),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) proto_err_q <= 1'b0;
    else if (out_of_order) proto_err_q <= 1'b1;
  end

  assign bus.slv_req     = slv_req_d;
  assign bus.slv_we      = bus.data_we;
  assign bus.slv_be      = bus.data_be;
  assign bus.slv_addr    = bus.data_addr;
  assign bus.slv_wdata   = bus.data_wdata;
  assign bus.data_gnt    = gnt;
  assign bus.data_rvalid = rvalid;
  assign bus.data_rdata  = rdata;
  assign bus.data_err    = rerr;
  assign bus.proto_err   = proto_err_q;

endmodule

// File: tb/tb_periph_bus_decoder.sv
// Directed bench: decode table plus multi-cycle ordering, full, reset and overlap sequences.
module tb_periph_bus_decoder;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  periph_bus_decoder_if #(.N_SLAVES(3)) bus ();
  periph_bus_decoder_if #(.N_SLAVES(3)) ovb ();

  periph_bus_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  periph_bus_decoder #(
    .SLV_MASK ({32'hFFFF_F000, 32'h0000_0000, 32'hFFFF_F000})
  ) dut_ov (
    .clk (clk),
    .rst (rst),
    .bus (ovb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [2:0]  sgnt;
    logic [2:0]  exp_req;
    logic        exp_gnt;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_be    = 4'h0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    bus.slv_gnt    = 3'b000;
    bus.slv_rvalid = 3'b000;
    bus.slv_rdata  = '0;
    bus.slv_err    = 3'b000;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [2:0] sgnt);
    bus.data_req  = 1'b1;
    bus.data_addr = addr;
    bus.slv_gnt   = sgnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0]  = '{1'b1, 32'h1000_0004, 3'b001, 3'b001, 1'b1};
    vecs[1]  = '{1'b1, 32'h1000_0004, 3'b000, 3'b001, 1'b0};
    vecs[2]  = '{1'b1, 32'h1000_0004, 3'b110, 3'b001, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0010, 3'b010, 3'b010, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_FFFC, 3'b010, 3'b010, 1'b1};
    vecs[5]  = '{1'b1, 32'h1000_1000, 3'b100, 3'b100, 1'b1};
    vecs[6]  = '{1'b1, 32'h1000_1FFF, 3'b100, 3'b100, 1'b1};
    vecs[7]  = '{1'b1, 32'h1000_2000, 3'b111, 3'b000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0001_0000, 3'b000, 3'b000, 1'b1};
    vecs[9]  = '{1'b0, 32'h1000_0004, 3'b111, 3'b000, 1'b0};
    vecs[10] = '{1'b1, 32'h1000_0FFC, 3'b001, 3'b001, 1'b1};

    idle();
    ovb.data_req   = 1'b0;
    ovb.data_we    = 1'b0;
    ovb.data_be    = 4'h0;
    ovb.data_addr  = 32'h0;
    ovb.data_wdata = 32'h0;
    ovb.slv_gnt    = 3'b000;
    ovb.slv_rvalid = 3'b000;
    ovb.slv_rdata  = '0;
    ovb.slv_err    = 3'b000;
    rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.data_gnt), 32'h0);
    chk("rst_rvalid", 32'(bus.data_rvalid), 32'h0);
    chk("rst_rdata", bus.data_rdata, 32'h0);
    chk("rst_err", 32'(bus.data_err), 32'h0);
    chk("rst_slv_req", 32'(bus.slv_req), 32'h0);
    chk("rst_proto_err", 32'(bus.proto_err), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Decode table: inputs are withdrawn before the next edge so nothing is pushed.
    for (int i = 0; i < 11; i++) begin
      bus.data_req   = vecs[i].req;
      bus.data_addr  = vecs[i].addr;
      bus.slv_gnt    = vecs[i].sgnt;
      bus.data_wdata = vecs[i].addr ^ 32'hFFFF_0000;
      bus.data_be    = 4'(i);
      bus.data_we    = i[0];
      #1;
      chk($sformatf("vec%0d_slv_req", i), 32'(bus.slv_req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_gnt", i), 32'(bus.data_gnt), 32'(vecs[i].exp_gnt));
      chk($sformatf("vec%0d_bcast", i),
          {bus.slv_addr[15:0] ^ bus.slv_wdata[15:0], 8'(bus.slv_be), 7'h0, bus.slv_we},
          {16'h0, 8'(i), 7'h0, i[0]});
      idle();
      tick();
    end
    chk("tbl_no_push_rvalid", 32'(bus.data_rvalid), 32'h0);

    // 1: slave0 read, response two cycles after grant
    drive(32'h1000_0004, 3'b001);
    #1;
    chk("s1_slv_req", 32'(bus.slv_req), 32'h1);
    chk("s1_gnt", 32'(bus.data_gnt), 32'h1);
    tick();
    idle();
    #1;
    chk("s1_wait_rvalid", 32'(bus.data_rvalid), 32'h0);
    tick();
    bus.slv_rvalid = 3'b001;
    bus.slv_rdata[31:0] = 32'hA5A5_0001;
    #1;
    chk("s1_rvalid", 32'(bus.data_rvalid), 32'h1);
    chk("s1_rdata", bus.data_rdata, 32'hA5A5_0001);
    chk("s1_err", 32'(bus.data_err), 32'h0);
    tick();
    idle();
    #1;
    chk("s1_popped", 32'(bus.data_rvalid), 32'h0);

    // 2: unmapped address answered by the error slave
    drive(32'h2000_0000, 3'b000);
    #1;
    chk("s2_gnt", 32'(bus.data_gnt), 32'h1);
    chk("s2_slv_req", 32'(bus.slv_req), 32'h0);
    chk("s2_no_same_cycle_rvalid", 32'(bus.data_rvalid), 32'h0);
    tick();
    idle();
    #1;
    chk("s2_rvalid", 32'(bus.data_rvalid), 32'h1);
    chk("s2_err", 32'(bus.data_err), 32'h1);
    chk("s2_rdata", bus.data_rdata, 32'h0);
    tick();
    chk("s2_popped", 32'(bus.data_rvalid), 32'h0);

    // 3: timer answers while RAM still pending
    drive(32'h0000_0010, 3'b010);
    #1;
    chk("s3_gnt_ram", 32'(bus.data_gnt), 32'h1);
    tick();
    drive(32'h1000_1000, 3'b100);
    #1;
    chk("s3_gnt_tmr", 32'(bus.data_gnt), 32'h1);
    tick();
    drive(32'h0000_0010, 3'b010);
    bus.slv_rvalid = 3'b100;
    #1;
    chk("s3_full_gnt", 32'(bus.data_gnt), 32'h0);
    chk("s3_full_req", 32'(bus.slv_req), 32'h0);
    chk("s3_dropped_rvalid", 32'(bus.data_rvalid), 32'h0);
    tick();
    idle();
    #1;
    chk("s3_proto_err", 32'(bus.proto_err), 32'h1);
    bus.slv_rvalid = 3'b010;
    bus.slv_rdata[63:32] = 32'h0000_0BAD;
    #1;
    chk("s3_ram_rdata", bus.data_rdata, 32'h0000_0BAD);
    tick();
    bus.slv_rvalid = 3'b100;
    bus.slv_rdata[95:64] = 32'h7777_0000;
    bus.slv_err = 3'b100;
    #1;
    chk("s3_tmr_rdata", bus.data_rdata, 32'h7777_0000);
    chk("s3_tmr_err", 32'(bus.data_err), 32'h1);
    tick();
    idle();
    rst = 1'b0;
    #1;
    chk("s3_rst_proto_err", 32'(bus.proto_err), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // 4: FIFO full, no bypass on the popping cycle
    drive(32'h0000_0020, 3'b010);
    tick();
    tick();
    #1;
    chk("s4_full_gnt", 32'(bus.data_gnt), 32'h0);
    tick();
    chk("s4_still_full", 32'(bus.data_gnt), 32'h0);
    bus.slv_rvalid = 3'b010;
    bus.slv_rdata[63:32] = 32'h1111_2222;
    #1;
    chk("s4_pop_rvalid", 32'(bus.data_rvalid), 32'h1);
    chk("s4_no_bypass", 32'(bus.data_gnt), 32'h0);
    tick();
    bus.slv_rvalid = 3'b000;
    #1;
    chk("s4_gnt_after_pop", 32'(bus.data_gnt), 32'h1);
    tick();
    idle();
    bus.slv_rvalid = 3'b010;
    #1;
    chk("s4_drain1", 32'(bus.data_rvalid), 32'h1);
    tick();
    #1;
    chk("s4_drain2", 32'(bus.data_rvalid), 32'h1);
    tick();
    #1;
    chk("s4_empty_proto", 32'(bus.proto_err), 32'h0);
    chk("s4_empty_rvalid", 32'(bus.data_rvalid), 32'h0);
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // 5: reset with a RAM read outstanding
    drive(32'h0000_0040, 3'b010);
    tick();
    idle();
    rst = 1'b0;
    bus.slv_rvalid = 3'b010;
    #1;
    chk("s5_rst_rvalid", 32'(bus.data_rvalid), 32'h0);
    tick();
    chk("s5_rst_rvalid2", 32'(bus.data_rvalid), 32'h0);
    chk("s5_rst_proto", 32'(bus.proto_err), 32'h0);
    rst = 1'b1;
    #1;
    chk("s5_late_rvalid", 32'(bus.data_rvalid), 32'h0);
    tick();
    chk("s5_proto_err", 32'(bus.proto_err), 32'h1);
    idle();

    // 6: overlapping map, lowest index wins
    ovb.data_req  = 1'b1;
    ovb.data_addr = 32'h1000_0000;
    #1;
    chk("s6_overlap_s0", 32'(ovb.slv_req), 32'h1);
    ovb.data_addr = 32'h2000_0000;
    #1;
    chk("s6_catchall_s1", 32'(ovb.slv_req), 32'h2);
    ovb.data_addr = 32'h1000_1004;
    #1;
    chk("s6_tmr_s1", 32'(ovb.slv_req), 32'h2);
    ovb.data_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
